// File: rtl/load_store_unit_pkg.sv
// Shared CPU definitions: opcode constants, LSU state encoding and the
// immediate sign-extension helper.
package cpu_defs;

  localparam logic [3:0] OP_CMP = 4'b1000;
  localparam logic [3:0] OP_LDR = 4'b1001;
  localparam logic [3:0] OP_STR = 4'b1010;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port between the load/store unit (master) and memory (slave).
interface load_store_unit_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/load_store_unit_addr_gen.sv
// Effective address: base plus sign-extended 16-bit offset, with a word
// misalignment flag.
module lsu_addr_gen
  import cpu_defs::*;
(
  input  logic [31:0] i_base,
  input  logic [15:0] i_imm,
  output logic [31:0] o_addr,
  output logic        o_misaligned
);

  assign o_addr       = i_base + sext16(i_imm);
  assign o_misaligned = |o_addr[1:0];

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one LDR/STR at a time as a req/ack memory transaction
// with timeout, and writes LDR results back to the register bank.
module load_store_unit
  import cpu_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit ALIGN_CHECK    = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [3:0]         OPCODE,
  input  logic [3:0]         dest_in,
  input  logic [31:0]        base,
  input  logic [31:0]        store_data,
  input  logic [15:0]        imm,
  output logic               busy,
  output logic               done,
  output logic               err,
  load_store_unit_if.master  mem,
  output logic [3:0]         dest,
  output logic [31:0]        ldr_data,
  output logic               REGBANK_ENABLE
);

  // Counter value seen in the last REQ cycle before giving up.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [31:0] w_addr;
  logic        w_misaligned;
  logic        w_accept;
  logic        w_fault;

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_is_ldr;
  logic        r_we;
  logic [3:0]  r_dest_lat;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [3:0]  r_dest;
  logic [31:0] r_ldr_data;

  lsu_addr_gen u_addr_gen (
    .i_base       (base),
    .i_imm        (imm),
    .o_addr       (w_addr),
    .o_misaligned (w_misaligned)
  );

  assign w_accept = start && (OPCODE == OP_LDR || OPCODE == OP_STR);
  assign w_fault  = ALIGN_CHECK && w_misaligned;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_ldr   <= 1'b0;
      r_we       <= 1'b0;
      r_dest_lat <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
      r_dest     <= '0;
      r_ldr_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_ldr   <= (OPCODE == OP_LDR);
            r_we       <= (OPCODE == OP_STR);
            r_dest_lat <= dest_in;
            r_addr     <= w_addr;
            r_wdata    <= store_data;
            r_cnt      <= '0;
            r_err      <= w_fault;
            r_state    <= w_fault ? S_DONE : S_REQ;
          end
        end
        S_REQ: begin
          // An ack in the final allowed cycle takes priority over the timeout.
          if (mem.mem_ack) begin
            if (r_is_ldr) begin
              r_ldr_data <= mem.mem_rdata;
              r_dest     <= r_dest_lat;
              r_state    <= S_WB;
            end else begin
              r_state <= S_DONE;
            end
          end else if (r_cnt == TO_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WB:    r_state <= S_IDLE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem.mem_req    = (r_state == S_REQ);
  assign mem.mem_we     = r_we;
  assign mem.mem_addr   = r_addr;
  assign mem.mem_wdata  = r_wdata;

  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_WB) || (r_state == S_DONE);
  assign REGBANK_ENABLE = (r_state == S_WB);
  assign err            = r_err;
  assign dest           = r_dest;
  assign ldr_data       = r_ldr_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized LDR/STR transactions against a transaction-level
// model of the load/store unit with a small memory responder.
module tb_load_store_unit;
  import cpu_defs::*;

  localparam int TO = 4;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [3:0]  opcode;
  logic [3:0]  dest_in;
  logic [31:0] base;
  logic [31:0] store_data;
  logic [15:0] imm;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  dest;
  logic [31:0] ldr_data;
  logic        regbank_enable;

  int compared;
  int mismatched;
  logic [3:0]  model_dest;
  logic [31:0] model_data;

  load_store_unit_if mem_bus ();

  load_store_unit #(
    .TIMEOUT_CYCLES (TO),
    .ALIGN_CHECK    (1'b1)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .OPCODE         (opcode),
    .dest_in        (dest_in),
    .base           (base),
    .store_data     (store_data),
    .imm            (imm),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .mem            (mem_bus.master),
    .dest           (dest),
    .ldr_data       (ldr_data),
    .REGBANK_ENABLE (regbank_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   32'(mem_bus.mem_req), 32'd0);
    chk({tag, "_we"},    32'(mem_bus.mem_we), 32'd0);
    chk({tag, "_addr"},  mem_bus.mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_bus.mem_wdata, 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_err"},   32'(err), 32'd0);
    chk({tag, "_dest"},  32'(dest), 32'd0);
    chk({tag, "_data"},  ldr_data, 32'd0);
    chk({tag, "_rbe"},   32'(regbank_enable), 32'd0);
  endtask

  // Called at a falling edge with the DUT idle. wait_n = idle cycles of
  // mem_req before the ack is given; wait_n >= TO means no ack at all.
  task automatic run_txn(input logic [3:0] op, input logic [3:0] dst, input logic [31:0] b,
                         input logic [31:0] sd, input logic [15:0] im, input int wait_n,
                         input logic [31:0] rd, input bit hold_start);
    logic [31:0] exp_addr;
    bit          exp_mis, exp_acked;
    int          exp_req, exp_rbe;
    int          req_cnt, rbe_cnt, done_cyc, bad_bus, busy_low;
    logic        err_at_done;
    logic [3:0]  seen_dest;
    logic [31:0] seen_data;

    exp_addr  = b + 32'($signed(im));
    exp_mis   = (exp_addr[1:0] != 2'b00);
    exp_acked = !exp_mis && (wait_n < TO);
    exp_req   = exp_mis ? 0 : (exp_acked ? wait_n + 1 : TO);
    exp_rbe   = (op == OP_LDR && exp_acked) ? 1 : 0;

    opcode = op; dest_in = dst; base = b; store_data = sd; imm = im; start = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;

    req_cnt = 0; rbe_cnt = 0; done_cyc = 0; bad_bus = 0; busy_low = 0;
    err_at_done = 1'bx; seen_dest = 'x; seen_data = 'x;
    for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = $urandom;
      if (mem_bus.mem_req) begin
        if (mem_bus.mem_addr !== exp_addr || mem_bus.mem_we !== (op == OP_STR) ||
            (op == OP_STR && mem_bus.mem_wdata !== sd))
          bad_bus++;
        if (req_cnt == wait_n) begin
          mem_bus.mem_ack   = 1'b1;
          mem_bus.mem_rdata = rd;
        end
        req_cnt++;
      end
      if (!busy) busy_low++;
      if (regbank_enable) begin
        rbe_cnt++; seen_dest = dest; seen_data = ldr_data;
      end
      if (done) begin
        done_cyc = cyc; err_at_done = err;
      end
      if (done_cyc == 0) @(negedge clk);
    end
    mem_bus.mem_ack = 1'b0;

    chk("done_seen", 32'(done_cyc != 0), 32'd1);
    chk("req_cycles", 32'(req_cnt), 32'(exp_req));
    chk("done_cycle", 32'(done_cyc), 32'(exp_req + 1));
    chk("bus_stable", 32'(bad_bus), 32'd0);
    chk("busy_during", 32'(busy_low), 32'd0);
    chk("rbe_cycles", 32'(rbe_cnt), 32'(exp_rbe));
    chk("err_at_done", 32'(err_at_done), 32'(!exp_acked));
    if (exp_rbe == 1) begin
      model_dest = dst;
      model_data = rd;
      chk("wb_dest", 32'(seen_dest), 32'(dst));
      chk("wb_data", seen_data, rd);
    end

    @(negedge clk);
    start = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("err_sticky", 32'(err), 32'(!exp_acked));
    chk("hold_dest", 32'(dest), 32'(model_dest));
    chk("hold_data", ldr_data, model_data);
    @(negedge clk);
    chk("no_retrigger", 32'({busy, mem_bus.mem_req}), 32'd0);

    $display("txn op=%h dest=%0d addr=%h wait=%0d req=%0d done@%0d err=%0b rbe=%0d",
             op, dst, exp_addr, wait_n, req_cnt, done_cyc, err_at_done, rbe_cnt);
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_base;

    compared = 0; mismatched = 0;
    model_dest = '0; model_data = '0;
    reset_n = 1'b0; start = 1'b0; opcode = '0; dest_in = '0;
    base = '0; store_data = '0; imm = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    run_txn(OP_LDR, 4'd5, 32'h100, 32'h0, 16'h0004, 2, 32'hDEADBEEF, 1'b0);
    run_txn(OP_STR, 4'd0, 32'h200, 32'h12345678, 16'hFFFC, 0, 32'h0, 1'b0);
    run_txn(OP_LDR, 4'd7, 32'h101, 32'h0, 16'h0000, 0, 32'h0, 1'b0);
    run_txn(OP_LDR, 4'd9, 32'h300, 32'h0, 16'h0008, 9, 32'h0, 1'b0);
    run_txn(OP_STR, 4'd0, 32'h400, 32'hCAFEF00D, 16'h0010, TO - 1, 32'h0, 1'b0);
    run_txn(OP_LDR, 4'd3, 32'h500, 32'h0, 16'h0000, TO - 1, 32'hA5A5A5A5, 1'b0);

    // Unsupported opcode held on start: nothing must happen.
    opcode = OP_CMP; start = 1'b1; base = 32'h600; imm = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cmp_idle", 32'({busy, done, mem_bus.mem_req}), 32'd0);
    end
    start = 1'b0;
    run_txn(OP_LDR, 4'd12, 32'h700, 32'h0, 16'h0004, 1, 32'h13572468, 1'b1);

    // Reset in the middle of a request aborts without writeback.
    opcode = OP_LDR; dest_in = 4'd6; base = 32'h800; imm = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_reset_req", 32'(mem_bus.mem_req), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    reset_n = 1'b1;
    model_dest = '0; model_data = '0;
    @(negedge clk);
    run_txn(OP_LDR, 4'd6, 32'h800, 32'h0, 16'h0000, 0, 32'h0BADF00D, 1'b0);

    for (int n = 0; n < 30; n++) begin
      r_op   = ($urandom_range(0, 1) == 0) ? OP_LDR : OP_STR;
      r_base = $urandom;
      if ($urandom_range(0, 3) != 0) r_base[1:0] = 2'b00;
      run_txn(r_op, 4'($urandom), r_base, $urandom, 16'($urandom) & 16'hFFFC,
              $urandom_range(0, TO + 1), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
